// File: rtl/alu_pkg.sv
// Shared ALU/divider constants, divider state encoding and ALU op codes.
// Used by seq_divider and div_step.
package alu_pkg;

  localparam int WIDTH       = 18;
  localparam int DIV_LATENCY = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } div_state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_MUL,
    ALU_DIV
  } alu_op_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift, trial subtract, restore.
// Quotient bits shift into the LSB of the dividend register.
module div_step
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_dvd,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_dvd
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;
  logic       w_qbit;

  assign w_shift = {i_rem, i_dvd[W-1]};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  assign w_qbit  = ~w_diff[W];

  assign o_rem = w_qbit ? w_diff[W-1:0] : w_shift[W-1:0];
  assign o_dvd = {i_dvd[W-2:0], w_qbit};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             DivZero,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative
);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_divzero;

  logic             w_accept;
  logic             w_dz;
  logic             w_last;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_dvd_nx;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign w_accept = start && (r_state != RUN);
  assign w_dz     = (divisor == '0);
  assign w_last   = (r_state == RUN) &&
                    (r_cnt == CNT_W'(WIDTH - 1));

  div_step #(
    .W (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_dvd (r_dvd),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nx),
    .o_dvd (w_dvd_nx)
  );

`ifdef SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;
  logic r_ovf;
  logic w_ovf;

  // Divide magnitudes; signs are restored when the result is written.
  assign w_a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_ovf   = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (&divisor);
  assign w_q_fin = r_neg_q ? -w_dvd_nx : w_dvd_nx;
  assign w_r_fin = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign OverFlow = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
      r_ovf   <= w_ovf;
    end
  end
`else
  assign w_a_mag  = dividend;
  assign w_b_mag  = divisor;
  assign w_q_fin  = w_dvd_nx;
  assign w_r_fin  = w_rem_nx;
  assign OverFlow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, FIN: begin
        if (start) begin
          w_next = w_dz ? FIN : RUN;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        w_next = w_last ? FIN : RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      RUN:     busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_quot    <= '0;
      r_remo    <= '0;
      r_divzero <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= w_a_mag;
      r_dvs     <= w_b_mag;
      r_divzero <= w_dz;
      if (w_dz) begin
        r_quot <= '1;
        r_remo <= dividend;
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_rem_nx;
      r_dvd <= w_dvd_nx;
      if (w_last) begin
        r_quot <= w_q_fin;
        r_remo <= w_r_fin;
      end
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign DivZero   = r_divzero;
  assign Zero      = (r_quot == '0);
  assign Negative  = r_quot[WIDTH-1];

endmodule
